// File: rtl/cfu_softmax_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cfu_softmax_sequencer
//  Purpose  : Issues EXP commands to the softmax CFU for each incoming logit,
//             streams back the exponentials, accumulates their sum,
//             normalizes it and issues a single RECIP command.
//  Revision : 1.0  initial release
// ============================================================================
module cfu_softmax_sequencer #(
    parameter int MAX_LEN = 16,
    parameter int SUM_W   = 36
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(MAX_LEN):0]  len,
    input  logic [31:0]               frac_bits,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [9:0]                cmd_payload_function_id,
    output logic [31:0]               cmd_payload_inputs_0,
    output logic [31:0]               cmd_payload_inputs_1,
    input  logic                      rsp_valid,
    output logic                      rsp_ready,
    input  logic [31:0]               rsp_payload_outputs_0,
    output logic                      exp_valid,
    output logic [31:0]               exp_data,
    output logic [SUM_W-1:0]          sum,
    output logic [31:0]               recip,
    output logic signed [5:0]         recip_shift,
    output logic                      busy,
    output logic                      done
);

    localparam int                 C_LEN_W      = $clog2(MAX_LEN) + 1;
    localparam logic [C_LEN_W-1:0] C_MAX_LEN    = C_LEN_W'(MAX_LEN);
    localparam logic [9:0]         C_FN_EXP     = 10'h000;
    localparam logic [9:0]         C_FN_RECIP   = 10'h008;
    localparam logic [31:0]        C_RECIP_FRAC = 32'd31;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_EXP_CMD   = 3'd2,
        S_EXP_RSP   = 3'd3,
        S_NORM      = 3'd4,
        S_RECIP_CMD = 3'd5,
        S_RECIP_RSP = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [C_LEN_W-1:0]    r_len;
    logic [C_LEN_W-1:0]    r_count;
    logic [C_LEN_W-1:0]    w_count_inc;
    logic [C_LEN_W-1:0]    w_len_clamped;
    logic                  w_last;
    logic [31:0]           r_frac;

    logic [9:0]            r_cmd_fn;
    logic [31:0]           r_cmd_in0;
    logic [31:0]           r_cmd_in1;
    logic                  r_exp_valid;
    logic [31:0]           r_exp_data;
    logic [SUM_W-1:0]      r_sum;
    logic [31:0]           r_recip;
    logic signed [5:0]     r_recip_shift;

    int                    w_msb;
    logic [31:0]           w_mant;
    logic signed [5:0]     w_shift;

    // Element bookkeeping: oversized requests are clamped to the block size.
    assign w_len_clamped = (len > C_MAX_LEN) ? C_MAX_LEN : len;
    assign w_count_inc   = r_count + 1'b1;
    assign w_last        = (w_count_inc == r_len);

    // State register; reset abandons any block in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake/status outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        cmd_valid   = 1'b0;
        rsp_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_EXP_CMD;
                end
            end
            S_EXP_CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    w_state_nxt = S_EXP_RSP;
                end
            end
            S_EXP_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    w_state_nxt = w_last ? S_NORM : S_FETCH;
                end
            end
            S_NORM: begin
                w_state_nxt = S_RECIP_CMD;
            end
            S_RECIP_CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    w_state_nxt = S_RECIP_RSP;
                end
            end
            S_RECIP_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Normalize the sum so its MSB lands on bit 30 (mantissa in [2^30, 2^31)).
    always_comb begin
        w_msb   = -1;
        w_mant  = 32'd0;
        w_shift = 6'sd0;
        for (int i = 0; i < SUM_W; i++) begin
            if (r_sum[i]) begin
                w_msb = i;
            end
        end
        if (w_msb >= 30) begin
            w_mant  = 32'(r_sum >> (w_msb - 30));
            w_shift = 6'(w_msb - 30);
        end else if (w_msb >= 0) begin
            w_mant  = 32'(r_sum << (30 - w_msb));
            w_shift = 6'(w_msb - 30);
        end
    end

    // Datapath: operand/payload capture, accumulation and result latching.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len         <= '0;
            r_count       <= '0;
            r_frac        <= 32'd0;
            r_cmd_fn      <= 10'd0;
            r_cmd_in0     <= 32'd0;
            r_cmd_in1     <= 32'd0;
            r_exp_valid   <= 1'b0;
            r_exp_data    <= 32'd0;
            r_sum         <= '0;
            r_recip       <= 32'd0;
            r_recip_shift <= 6'sd0;
        end else begin
            r_exp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= w_len_clamped;
                        r_frac  <= frac_bits;
                        r_count <= '0;
                        r_sum   <= '0;
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        r_cmd_fn  <= C_FN_EXP;
                        r_cmd_in0 <= r_frac;
                        r_cmd_in1 <= in_data;
                    end
                end
                S_EXP_RSP: begin
                    if (rsp_valid) begin
                        r_sum       <= r_sum + SUM_W'(rsp_payload_outputs_0);
                        r_exp_valid <= 1'b1;
                        r_exp_data  <= rsp_payload_outputs_0;
                        r_count     <= w_count_inc;
                    end
                end
                S_NORM: begin
                    r_cmd_fn      <= C_FN_RECIP;
                    r_cmd_in0     <= C_RECIP_FRAC;
                    r_cmd_in1     <= w_mant;
                    r_recip_shift <= w_shift;
                end
                S_RECIP_RSP: begin
                    if (rsp_valid) begin
                        r_recip <= rsp_payload_outputs_0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_payload_function_id = r_cmd_fn;
    assign cmd_payload_inputs_0    = r_cmd_in0;
    assign cmd_payload_inputs_1    = r_cmd_in1;
    assign exp_valid               = r_exp_valid;
    assign exp_data                = r_exp_data;
    assign sum                     = r_sum;
    assign recip                   = r_recip;
    assign recip_shift             = r_recip_shift;

endmodule
`default_nettype wire
